// File: rtl/cpu_pkg.sv
// Shared CPU constants and the instruction-fetch state encoding.
package cpu_pkg;

  localparam int WORD_W = 16;
  localparam int ADDR_W = 16;

  localparam logic [ADDR_W-1:0] RESET_PC_DEF = 16'h0000;

  // FETCH: request out; HOLD: word presented; FLUSH: drain a cancelled
  // request; ERR: memory stopped answering.
  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_ERR   = 2'd3
  } fetch_state_e;

  // True while a memory read is outstanding.
  function automatic logic is_busy(input fetch_state_e s);
    return (s == ST_FETCH) || (s == ST_FLUSH);
  endfunction

endpackage

// File: rtl/fetch_watchdog.sv
// Fetch timeout counter. Present only when FETCH_TIMEOUT_EN is defined.
`ifdef FETCH_TIMEOUT_EN
module fetch_watchdog #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic busy,     // a read is outstanding this cycle
  input  logic restart,  // ack or state change: start counting afresh
  output logic expired   // this cycle is the last one allowed
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt;

  // Count consecutive busy cycles with no ack; the top leaves FETCH/FLUSH on expiry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  cnt <= '0;
    else if (!busy || restart)  cnt <= '0;
    else if (!expired)          cnt <= cnt + CW'(1);
  end

  assign expired = busy && !restart && (cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule
`endif

// File: rtl/instr_fetch.sv
// Instruction fetch unit: one outstanding word read, redirect/flush handling.
// Optional fetch timeout enabled by defining FETCH_TIMEOUT_EN.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC       = RESET_PC_DEF,
  parameter int                TIMEOUT_CYCLES = 15
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic [WORD_W-1:0] instr,
  output logic              instr_valid,
  input  logic              instr_taken,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] pc,
  output logic              fetch_err
);

  fetch_state_e      state;
  logic [ADDR_W-1:0] pending_pc;
  logic              timeout_hit;

`ifdef FETCH_TIMEOUT_EN
  logic wd_restart;

  // Ack ends the wait; FETCH->FLUSH is a state change. FLUSH+redirect is not.
  assign wd_restart = mem_ack || ((state == ST_FETCH) && redirect);

  fetch_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (
    .clk     (clk),
    .reset   (reset),
    .busy    (is_busy(state)),
    .restart (wd_restart),
    .expired (timeout_hit)
  );

  // ERR is only left by reset, so the state itself is the sticky flag.
  assign fetch_err = (state == ST_ERR);
`else
  logic unused_timeout_cfg;

  assign timeout_hit        = 1'b0;
  assign fetch_err          = 1'b0;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  // Fetch FSM with registered mem_rd / instr_valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_FETCH;
      mem_rd      <= 1'b1;
      instr_valid <= 1'b0;
      mem_addr    <= RESET_PC;
      pc          <= RESET_PC;
      pending_pc  <= RESET_PC;
      instr       <= '0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (timeout_hit) begin
            state  <= ST_ERR;
            mem_rd <= 1'b0;
          end else if (redirect) begin
            // Data of the in-flight read is stale; if it already returned,
            // reissue at the target, otherwise wait it out in FLUSH while
            // keeping the request stable.
            if (mem_ack) begin
              mem_addr <= redirect_pc;
            end else begin
              pending_pc <= redirect_pc;
              state      <= ST_FLUSH;
            end
          end else if (mem_ack) begin
            instr       <= mem_rdata;
            pc          <= mem_addr;
            state       <= ST_HOLD;
            mem_rd      <= 1'b0;
            instr_valid <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (redirect || instr_taken) begin
            mem_addr    <= redirect ? redirect_pc : pc + ADDR_W'(1);
            state       <= ST_FETCH;
            mem_rd      <= 1'b1;
            instr_valid <= 1'b0;
          end
        end
        ST_FLUSH: begin
          if (timeout_hit) begin
            state  <= ST_ERR;
            mem_rd <= 1'b0;
          end else begin
            if (redirect) pending_pc <= redirect_pc;
            if (mem_ack) begin
              mem_addr <= redirect ? redirect_pc : pending_pc;
              state    <= ST_FETCH;
            end
          end
        end
        ST_ERR: begin
          mem_rd      <= 1'b0;
          instr_valid <= 1'b0;
        end
        default: begin
          state <= ST_ERR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: a memory model with variable latency,
// a stimulus process that predicts the address of the next delivered word,
// and a monitor that checks every newly valid word against the prediction.
module tb_instr_fetch;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_rd, mem_ack = 1'b0;
  logic [15:0] mem_addr, mem_rdata = 16'h0;
  logic [15:0] instr, pc;
  logic        instr_valid, fetch_err;
  logic        instr_taken = 1'b0, redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(RESET_PC_DEF), .TIMEOUT_CYCLES(15)) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_rd      (mem_rd),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_taken (instr_taken),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .pc          (pc),
    .fetch_err   (fetch_err)
  );

  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_q[$];     // address of the next word the fetch unit must deliver
  logic [15:0] req_log[$];   // addresses of memory requests, in issue order
  logic [15:0] cur_pc = 16'h0;
  int          delivered = 0;
  int          lat_mode = 0; // fixed wait cycles, -1 random 0..3, 99 never ack

  function automatic logic [15:0] memfn(input logic [15:0] a);
    if (a == 16'h0000) return 16'h5012;
    return (a * 16'h9E37) ^ 16'hC3A5;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory: one request at a time, ack after lat_mode wait cycles.
  bit          outstanding = 0;
  int          wait_left = 0;
  logic [15:0] req_addr = 16'h0;
  always @(negedge clk) begin
    if (reset || !mem_rd) begin
      outstanding = 0;
      mem_ack     = 1'b0;
    end else begin
      if (!outstanding) begin
        outstanding = 1;
        req_addr    = mem_addr;
        req_log.push_back(mem_addr);
        wait_left   = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
      end else begin
        chk("addr_stable", mem_addr, req_addr);
      end
      if (wait_left == 0 && lat_mode != 99) begin
        mem_ack     = 1'b1;
        mem_rdata   = memfn(req_addr);
        outstanding = 0;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 16'($urandom);
        if (wait_left > 0) wait_left--;
      end
    end
  end

  // Monitor: each rising instr_valid is one delivered word.
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    logic [15:0] e;
    if (reset) begin
      prev_valid = 1'b0;
    end else begin
      if (instr_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got pc=%h instr=%h expected no word", pc, instr);
        end else begin
          e = exp_q.pop_front();
          chk("word_pc", pc, e);
          chk("word_instr", instr, memfn(e));
          cur_pc = e;
          delivered++;
        end
      end
      prev_valid = instr_valid;
    end
  end

  // Drive one cycle of inputs and record what the fetch unit must deliver next.
  task automatic step(input bit rd, input logic [15:0] rpc, input bit tk);
    redirect    = rd;
    redirect_pc = rpc;
    instr_taken = tk;
    if (rd) begin
      exp_q.delete();
      exp_q.push_back(rpc);
    end else if (tk && instr_valid) begin
      exp_q.push_back(cur_pc + 16'd1);
    end
    @(negedge clk); #2;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    redirect    = 1'b0;
    instr_taken = 1'b0;
    redirect_pc = 16'h0;
    exp_q.delete();
    @(negedge clk); #2;
    @(negedge clk); #2;
    req_log.delete();
    reset = 1'b0;
    exp_q.push_back(RESET_PC_DEF);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!instr_valid && n < 30) begin
      step(1'b0, 16'h0, 1'b0);
      n++;
    end
    chk("wait_valid", instr_valid, 1);
  endtask

  initial begin
    int base;
    // Reset state.
    @(negedge clk); #2;
    chk("rst_mem_rd", mem_rd, 1);
    chk("rst_valid", instr_valid, 0);
    chk("rst_mem_addr", mem_addr, RESET_PC_DEF);
    chk("rst_pc", pc, RESET_PC_DEF);
    chk("rst_instr", instr, 0);
    chk("rst_fetch_err", fetch_err, 0);

    // Zero-wait memory, first word 5012 at address 0, then advance.
    lat_mode = 0;
    do_reset();
    step(1'b0, 16'h0, 1'b0);
    chk("zw_mem_rd", mem_rd, 1);
    chk("zw_not_yet_valid", instr_valid, 0);
    step(1'b0, 16'h0, 1'b0);
    chk("zw_valid", instr_valid, 1);
    chk("zw_instr", instr, 16'h5012);
    chk("zw_pc", pc, 0);
    step(1'b0, 16'h0, 1'b1);
    chk("zw_next_addr", mem_addr, 1);
    chk("zw_valid_drop", instr_valid, 0);
    chk("zw_instr_kept", instr, 16'h5012);
    wait_valid();

    // Three-cycle memory, instr_taken held high.
    lat_mode = 2;
    do_reset();
    base = delivered;
    for (int i = 0; i < 40 && (delivered - base) < 3; i++) step(1'b0, 16'h0, 1'b1);
    chk("lat3_words", delivered - base, 3);
    chk("lat3_reqs", req_log.size(), 3);
    for (int i = 0; i < 3 && i < req_log.size(); i++) chk("lat3_req_addr", req_log[i], i);
    step(1'b0, 16'h0, 1'b0);

    // Redirect while a slow read is in flight: old data is discarded.
    lat_mode = 3;
    do_reset();
    step(1'b0, 16'h0, 1'b0);
    step(1'b1, 16'h0040, 1'b0);
    chk("flush_mem_rd", mem_rd, 1);
    chk("flush_addr_held", mem_addr, 0);
    chk("flush_no_valid", instr_valid, 0);
    wait_valid();
    chk("flush_reqs", req_log.size(), 2);
    if (req_log.size() == 2) chk("flush_next_addr", req_log[1], 16'h0040);

    // PC wrap and redirect priority over instr_taken.
    lat_mode = 0;
    do_reset();
    step(1'b1, 16'hFFFF, 1'b0);
    wait_valid();
    chk("wrap_pc", pc, 16'hFFFF);
    step(1'b0, 16'h0, 1'b1);
    chk("wrap_addr", mem_addr, 16'h0000);
    wait_valid();
    step(1'b1, 16'h0100, 1'b1);
    chk("redir_prio_addr", mem_addr, 16'h0100);
    chk("redir_prio_valid", instr_valid, 0);
    wait_valid();

    // Random traffic.
    lat_mode = -1;
    do_reset();
    for (int i = 0; i < 500; i++)
      step($urandom_range(0, 9) == 0, 16'($urandom), 1'($urandom_range(0, 1)));
    step(1'b0, 16'h0, 1'b0);
    wait_valid();
    chk("rand_drained", exp_q.size(), 0);
    chk("rand_no_err", fetch_err, 0);

`ifdef FETCH_TIMEOUT_EN
    // Memory never answers: error after 15 cycles, sticky until reset.
    lat_mode = 99;
    do_reset();
    repeat (14) step(1'b0, 16'h0, 1'b0);
    chk("to_pre_err", fetch_err, 0);
    chk("to_pre_rd", mem_rd, 1);
    step(1'b0, 16'h0, 1'b0);
    chk("to_err", fetch_err, 1);
    chk("to_rd_low", mem_rd, 0);
    repeat (5) step(1'b1, 16'h0200, 1'b1);
    chk("to_sticky", fetch_err, 1);
    chk("to_sticky_valid", instr_valid, 0);
    lat_mode = 0;
    do_reset();
    chk("to_cleared", fetch_err, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

endmodule
